// File: rtl/pipe_controller_ext_pkg.sv
// rtl/pipe_controller_ext_pkg.sv - shared ALU, DP opcode, condition and flag constants for the pipe controller
package pipe_controller_ext_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100,
        ALU_MOV = 3'b101
    } aluOpT;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] DP_AND = 4'h0;
    localparam logic [3:0] DP_EOR = 4'h1;
    localparam logic [3:0] DP_SUB = 4'h2;
    localparam logic [3:0] DP_ADD = 4'h4;
    localparam logic [3:0] DP_TST = 4'h8;
    localparam logic [3:0] DP_CMP = 4'hA;
    localparam logic [3:0] DP_ORR = 4'hC;
    localparam logic [3:0] DP_MOV = 4'hD;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/pipe_controller_ext_cond.sv
// rtl/pipe_controller_ext_cond.sv - condition evaluation and per-field NZCV next-value selection
module pipe_controller_ext_cond
    import pipe_controller_ext_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    input  logic [3:0] aluFlags,
    input  logic [1:0] flagWrite,
    output logic       condEx,
    output logic [3:0] flagsNext
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        condEx = 1'b0;
        case (cond)
            COND_EQ: condEx = z;
            COND_NE: condEx = ~z;
            COND_CS: condEx = c;
            COND_CC: condEx = ~c;
            COND_MI: condEx = n;
            COND_PL: condEx = ~n;
            COND_VS: condEx = v;
            COND_VC: condEx = ~v;
            COND_HI: condEx = c & ~z;
            COND_LS: condEx = ~c | z;
            COND_GE: condEx = (n == v);
            COND_LT: condEx = (n != v);
            COND_GT: condEx = ~z & (n == v);
            COND_LE: condEx = z | (n != v);
            COND_AL: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end

    // N,Z follow flagWrite[1]; C,V follow flagWrite[0]
    assign flagsNext[3:2] = (condEx & flagWrite[1]) ? aluFlags[3:2] : flags[3:2];
    assign flagsNext[1:0] = (condEx & flagWrite[0]) ? aluFlags[1:0] : flags[1:0];

endmodule

// File: rtl/pipe_controller_ext.sv
// rtl/pipe_controller_ext.sv - decode plus E/M/W control pipeline with private NZCV register
module pipe_controller_ext
    import pipe_controller_ext_pkg::*;
#(
    parameter int EXT_ALU    = 1,
    parameter int ALU_CTRL_W = 3,
    parameter int NUM_FLAGS  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:12]          InstrD,
    input  logic [NUM_FLAGS-1:0]  ALUFlagsE,
    input  logic                  StallE,
    input  logic                  FlushE,
    output logic [1:0]            RegSrcD,
    output logic [1:0]            ImmSrcD,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic                  ALUSrcE,
    output logic                  MemtoRegE,
    output logic                  BranchTakenE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic                  PCSrcW,
    output logic                  PCWrPendingF,
    output logic [NUM_FLAGS-1:0]  FlagsE
);

    aluOpT      aluCode;
    logic       aluSrcD, regWriteD, memWriteD, memtoRegD, branchD, pcSrcD;
    logic [1:0] flagWriteD;
    logic       opKnown, isCompare, isArith, sBit;
    logic       unusedRn;

    logic       branchE, memWriteE, regWriteE, pcSrcE, condExE;
    logic [1:0] flagWriteE;
    logic [3:0] condE;
    logic [NUM_FLAGS-1:0] flagsNext;

    logic       memtoRegM, pcSrcM;

    assign unusedRn = ^InstrD[19:16];

    always_comb begin
        RegSrcD    = 2'b00;
        ImmSrcD    = 2'b00;
        aluCode    = ALU_ADD;
        aluSrcD    = 1'b0;
        regWriteD  = 1'b0;
        memWriteD  = 1'b0;
        memtoRegD  = 1'b0;
        branchD    = 1'b0;
        flagWriteD = 2'b00;
        opKnown    = 1'b0;
        isCompare  = 1'b0;
        isArith    = 1'b0;
        sBit       = 1'b0;
        case (InstrD[27:26])
            OP_DP: begin
                aluSrcD = InstrD[25];
                case (InstrD[24:21])
                    DP_ADD: begin aluCode = ALU_ADD; opKnown = 1'b1; isArith = 1'b1; end
                    DP_SUB: begin aluCode = ALU_SUB; opKnown = 1'b1; isArith = 1'b1; end
                    DP_AND: begin aluCode = ALU_AND; opKnown = 1'b1; end
                    DP_ORR: begin aluCode = ALU_ORR; opKnown = 1'b1; end
                    DP_EOR: if (EXT_ALU != 0) begin aluCode = ALU_EOR; opKnown = 1'b1; end
                    DP_MOV: if (EXT_ALU != 0) begin aluCode = ALU_MOV; opKnown = 1'b1; end
                    DP_CMP: if (EXT_ALU != 0) begin
                        aluCode = ALU_SUB; opKnown = 1'b1; isArith = 1'b1; isCompare = 1'b1;
                    end
                    DP_TST: if (EXT_ALU != 0) begin
                        aluCode = ALU_AND; opKnown = 1'b1; isCompare = 1'b1;
                    end
                    default: ;
                endcase
                // compares carry an implied S bit and never write a register
                sBit       = InstrD[20] | isCompare;
                regWriteD  = opKnown & ~isCompare;
                flagWriteD = opKnown ? {sBit, sBit & isArith} : 2'b00;
            end
            OP_MEM: begin
                aluSrcD = 1'b1;
                ImmSrcD = 2'b01;
                if (InstrD[20]) begin
                    regWriteD = 1'b1;
                    memtoRegD = 1'b1;
                end else begin
                    memWriteD = 1'b1;
                    RegSrcD   = 2'b10;
                end
            end
            OP_BR: begin
                RegSrcD = 2'b01;
                ImmSrcD = 2'b10;
                aluSrcD = 1'b1;
                branchD = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcSrcD = ((InstrD[15:12] == 4'hF) & regWriteD) | branchD;

    always_ff @(posedge clk) begin
        if (reset) begin
            branchE     <= 1'b0;
            memWriteE   <= 1'b0;
            regWriteE   <= 1'b0;
            pcSrcE      <= 1'b0;
            MemtoRegE   <= 1'b0;
            flagWriteE  <= 2'b00;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
            condE       <= 4'h0;
        end else begin
            if (FlushE) begin
                branchE    <= 1'b0;
                memWriteE  <= 1'b0;
                regWriteE  <= 1'b0;
                pcSrcE     <= 1'b0;
                MemtoRegE  <= 1'b0;
                flagWriteE <= 2'b00;
            end else if (!StallE) begin
                branchE    <= branchD;
                memWriteE  <= memWriteD;
                regWriteE  <= regWriteD;
                pcSrcE     <= pcSrcD;
                MemtoRegE  <= memtoRegD;
                flagWriteE <= flagWriteD;
            end
            // datapath selects survive a flush; the cleared writes make them harmless
            if (!StallE) begin
                ALUSrcE     <= aluSrcD;
                ALUControlE <= ALU_CTRL_W'(aluCode);
                condE       <= InstrD[31:28];
            end
        end
    end

    pipe_controller_ext_cond u_cond (
        .cond      (condE),
        .flags     (FlagsE),
        .aluFlags  (ALUFlagsE),
        .flagWrite (flagWriteE & {2{~StallE}}),
        .condEx    (condExE),
        .flagsNext (flagsNext)
    );

    always_ff @(posedge clk) begin
        if (reset) FlagsE <= '0;
        else       FlagsE <= flagsNext;
    end

    assign BranchTakenE = branchE & condExE;

    always_ff @(posedge clk) begin
        if (reset || StallE) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            memtoRegM <= 1'b0;
            pcSrcM    <= 1'b0;
        end else begin
            RegWriteM <= regWriteE & condExE;
            MemWriteM <= memWriteE & condExE;
            memtoRegM <= MemtoRegE;
            pcSrcM    <= pcSrcE & condExE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
        end else begin
            RegWriteW <= RegWriteM;
            MemtoRegW <= memtoRegM;
            PCSrcW    <= pcSrcM;
        end
    end

    assign PCWrPendingF = pcSrcD | pcSrcE | pcSrcM;

endmodule

// File: tb/tb_pipe_controller_ext.sv
// tb/tb_pipe_controller_ext.sv - directed and randomized bench for pipe_controller_ext, EXT_ALU=1 and EXT_ALU=0
module tb_pipe_controller_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] instr;
    logic [3:0]  aluFlags;
    logic        stallE, flushE;

    logic [1:0] RegSrcD1, ImmSrcD1, RegSrcD0, ImmSrcD0;
    logic [2:0] ALUControlE1;
    logic [1:0] ALUControlE0;
    logic       ALUSrcE1, MemtoRegE1, BranchTakenE1, RegWriteM1, MemWriteM1;
    logic       RegWriteW1, MemtoRegW1, PCSrcW1, PCWrPendingF1;
    logic       ALUSrcE0, MemtoRegE0, BranchTakenE0, RegWriteM0, MemWriteM0;
    logic       RegWriteW0, MemtoRegW0, PCSrcW0, PCWrPendingF0;
    logic [3:0] FlagsE1, FlagsE0;

    int passed = 0;
    int total  = 0;
    bit modelValid = 0;

    always #5 clk = ~clk;

    pipe_controller_ext #(.EXT_ALU(1), .ALU_CTRL_W(3), .NUM_FLAGS(4)) dut1 (
        .clk(clk), .reset(reset), .InstrD(instr), .ALUFlagsE(aluFlags),
        .StallE(stallE), .FlushE(flushE), .RegSrcD(RegSrcD1), .ImmSrcD(ImmSrcD1),
        .ALUControlE(ALUControlE1), .ALUSrcE(ALUSrcE1), .MemtoRegE(MemtoRegE1),
        .BranchTakenE(BranchTakenE1), .RegWriteM(RegWriteM1), .MemWriteM(MemWriteM1),
        .RegWriteW(RegWriteW1), .MemtoRegW(MemtoRegW1), .PCSrcW(PCSrcW1),
        .PCWrPendingF(PCWrPendingF1), .FlagsE(FlagsE1)
    );

    pipe_controller_ext #(.EXT_ALU(0), .ALU_CTRL_W(2), .NUM_FLAGS(4)) dut0 (
        .clk(clk), .reset(reset), .InstrD(instr), .ALUFlagsE(aluFlags),
        .StallE(stallE), .FlushE(flushE), .RegSrcD(RegSrcD0), .ImmSrcD(ImmSrcD0),
        .ALUControlE(ALUControlE0), .ALUSrcE(ALUSrcE0), .MemtoRegE(MemtoRegE0),
        .BranchTakenE(BranchTakenE0), .RegWriteM(RegWriteM0), .MemWriteM(MemWriteM0),
        .RegWriteW(RegWriteW0), .MemtoRegW(MemtoRegW0), .PCSrcW(PCSrcW0),
        .PCWrPendingF(PCWrPendingF0), .FlagsE(FlagsE0)
    );

    typedef struct {
        logic       rw, mw, m2r, br, pcs, alusrc, aluOk;
        logic [1:0] fw, regsrc, immsrc;
        logic [2:0] alu;
        logic [3:0] cond;
    } ctl_t;

    ctl_t       mE[2], mM[2], mW[2];
    logic [3:0] mFlags[2];

    localparam logic [19:0] I_SUBS  = 20'hE0521;
    localparam logic [19:0] I_ADDEQ = 20'h00824;
    localparam logic [19:0] I_CMP   = 20'hE1520;
    localparam logic [19:0] I_NOP   = 20'hEC000;
    localparam logic [19:0] I_BNE   = 20'h1A000;
    localparam logic [19:0] I_ADD   = 20'hE0821;
    localparam logic [19:0] I_LDRPC = 20'hE59FF;
    localparam logic [19:0] I_ADDS  = 20'hE0921;
    localparam logic [19:0] I_LDR   = 20'hE5932;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic ctl_t blank();
        ctl_t d;
        d = '{default: '0};
        d.aluOk = 1'b1;
        return d;
    endfunction

    // instruction meaning from the ARM-subset rules, in full 32-bit bit positions
    function automatic ctl_t decode(logic [19:0] v, bit ext);
        ctl_t d;
        logic [31:0] w;
        bit known, cmp, arith, s;
        d = blank();
        w = {v, 12'h000};
        d.cond = w[31:28];
        known = 1; cmp = 0; arith = 0;
        case (w[27:26])
            2'd0: begin
                d.alusrc = w[25];
                case (w[24:21])
                    4'd4:  begin d.alu = 3'd0; arith = 1; end
                    4'd2:  begin d.alu = 3'd1; arith = 1; end
                    4'd0:  d.alu = 3'd2;
                    4'd12: d.alu = 3'd3;
                    4'd1:  if (ext) d.alu = 3'd4; else known = 0;
                    4'd13: if (ext) d.alu = 3'd5; else known = 0;
                    4'd10: if (ext) begin d.alu = 3'd1; arith = 1; cmp = 1; end else known = 0;
                    4'd8:  if (ext) begin d.alu = 3'd2; cmp = 1; end else known = 0;
                    default: known = 0;
                endcase
                if (!known) d.aluOk = 1'b0;
                else begin
                    s = w[20] || cmp;
                    d.rw = !cmp;
                    d.fw = {s, s && arith};
                end
            end
            2'd1: begin
                d.alusrc = 1; d.immsrc = 2'b01;
                if (w[20]) begin d.rw = 1; d.m2r = 1; end
                else begin d.mw = 1; d.regsrc = 2'b10; end
            end
            2'd2: begin
                d.regsrc = 2'b01; d.immsrc = 2'b10; d.alusrc = 1; d.br = 1;
            end
            default: ;
        endcase
        d.pcs = (w[15:12] == 4'hF && d.rw) || d.br;
        return d;
    endfunction

    // condition pairs share a base test; odd codes invert it (AL/NV fall out naturally)
    function automatic bit condHolds(logic [3:0] c, logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic void modelStep(int k, bit ext);
        ctl_t d, nE, nM, nW;
        bit ce;
        if (reset) begin
            mE[k] = blank(); mM[k] = blank(); mW[k] = blank(); mFlags[k] = 4'h0;
            return;
        end
        ce = condHolds(mE[k].cond, mFlags[k]);
        d  = decode(instr, ext);
        nW = mM[k];
        nM = blank();
        if (!stallE) begin
            nM.rw = mE[k].rw & ce; nM.mw = mE[k].mw & ce;
            nM.m2r = mE[k].m2r; nM.pcs = mE[k].pcs & ce;
            if (ce && mE[k].fw[1]) mFlags[k][3:2] = aluFlags[3:2];
            if (ce && mE[k].fw[0]) mFlags[k][1:0] = aluFlags[1:0];
        end
        nE = mE[k];
        if (!stallE) nE = d;
        if (flushE) begin
            nE.rw = 0; nE.mw = 0; nE.m2r = 0; nE.br = 0; nE.pcs = 0; nE.fw = 2'b00;
        end
        mE[k] = nE; mM[k] = nM; mW[k] = nW;
    endfunction

    task automatic checkComb();
        ctl_t d;
        d = decode(instr, 1);
        chk("RegSrcD", 8'(RegSrcD1), 8'(d.regsrc));
        chk("ImmSrcD", 8'(ImmSrcD1), 8'(d.immsrc));
        if (modelValid) begin
            for (int k = 0; k < 2; k++) begin
                d = decode(instr, k == 1);
                chk(k ? "x1.PCWrPendingF" : "x0.PCWrPendingF", 8'(k ? PCWrPendingF1 : PCWrPendingF0),
                    8'(d.pcs | mE[k].pcs | mM[k].pcs));
                chk(k ? "x1.BranchTakenE" : "x0.BranchTakenE", 8'(k ? BranchTakenE1 : BranchTakenE0),
                    8'(mE[k].br & condHolds(mE[k].cond, mFlags[k])));
            end
        end
    endtask

    task automatic checkRegs(int k);
        string p;
        p = k ? "x1." : "x0.";
        chk({p, "MemtoRegE"}, 8'(k ? MemtoRegE1 : MemtoRegE0), 8'(mE[k].m2r));
        chk({p, "ALUSrcE"}, 8'(k ? ALUSrcE1 : ALUSrcE0), 8'(mE[k].alusrc));
        if (mE[k].aluOk)
            chk({p, "ALUControlE"}, 8'(k ? ALUControlE1 : {1'b0, ALUControlE0}),
                8'(k ? mE[k].alu : {1'b0, mE[k].alu[1:0]}));
        chk({p, "RegWriteM"}, 8'(k ? RegWriteM1 : RegWriteM0), 8'(mM[k].rw));
        chk({p, "MemWriteM"}, 8'(k ? MemWriteM1 : MemWriteM0), 8'(mM[k].mw));
        chk({p, "RegWriteW"}, 8'(k ? RegWriteW1 : RegWriteW0), 8'(mW[k].rw));
        chk({p, "MemtoRegW"}, 8'(k ? MemtoRegW1 : MemtoRegW0), 8'(mW[k].m2r));
        chk({p, "PCSrcW"}, 8'(k ? PCSrcW1 : PCSrcW0), 8'(mW[k].pcs));
        chk({p, "FlagsE"}, 8'(k ? FlagsE1 : FlagsE0), 8'(mFlags[k]));
    endtask

    task automatic runCycle(input logic [19:0] ins, input logic [3:0] flg,
                            input logic st, input logic fl, input logic rs);
        instr = ins; aluFlags = flg; stallE = st; flushE = fl; reset = rs;
        #1;
        checkComb();
        modelStep(1, 1);
        modelStep(0, 0);
        if (rs) modelValid = 1;
        @(posedge clk);
        #1;
        if (modelValid) begin
            checkRegs(1);
            checkRegs(0);
        end
    endtask

    initial begin
        runCycle(20'($urandom), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1);
        runCycle(20'($urandom), 4'($urandom_range(0, 15)), 1'b1, 1'b1, 1'b1);
        chk("rst.FlagsE", 8'(FlagsE1), 8'h00);
        chk("rst.RegWriteW", 8'(RegWriteW1 | RegWriteW0 | PCSrcW1 | MemtoRegW1), 8'h00);
        chk("rst.MemtoRegE", 8'(MemtoRegE1 | RegWriteM1 | MemWriteM1 | BranchTakenE1), 8'h00);

        runCycle(I_SUBS, 4'h0, 1'b0, 1'b0, 1'b0);
        runCycle(I_ADDEQ, 4'h6, 1'b0, 1'b0, 1'b0);
        chk("subs.FlagsE", 8'(FlagsE1), 8'h06);
        runCycle(I_CMP, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("addeq.RegWriteM", 8'(RegWriteM1), 8'h01);
        runCycle(I_NOP, 4'h9, 1'b0, 1'b0, 1'b0);
        chk("cmp.x1.FlagsE", 8'(FlagsE1), 8'h09);
        chk("cmp.x0.FlagsE", 8'(FlagsE0), 8'h06);
        chk("cmp.RegWriteM", 8'({RegWriteM1, RegWriteM0}), 8'h00);

        runCycle(I_BNE, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("bne.BranchTakenE", 8'(BranchTakenE1), 8'h01);
        chk("bne.x0.BranchTakenE", 8'(BranchTakenE0), 8'h00);
        runCycle(I_ADD, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("flush.BranchTakenE", 8'(BranchTakenE1), 8'h00);

        runCycle(I_LDRPC, 4'h0, 1'b0, 1'b0, 1'b0);
        runCycle(I_NOP, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("ldrpc.early.PCSrcW", 8'(PCSrcW1), 8'h00);
        runCycle(I_NOP, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("ldrpc.PCSrcW", 8'(PCSrcW1), 8'h01);

        runCycle(I_ADDS, 4'h0, 1'b0, 1'b0, 1'b0);
        runCycle(I_LDR, 4'hF, 1'b1, 1'b0, 1'b0);
        chk("stall1.RegWriteM", 8'(RegWriteM1), 8'h00);
        chk("stall1.FlagsE", 8'(FlagsE1), 8'h09);
        runCycle(I_LDR, 4'hF, 1'b1, 1'b0, 1'b0);
        chk("stall2.FlagsE", 8'(FlagsE1), 8'h09);
        runCycle(I_LDR, 4'h2, 1'b0, 1'b0, 1'b0);
        chk("adds.FlagsE", 8'(FlagsE1), 8'h02);
        chk("adds.RegWriteM", 8'(RegWriteM1), 8'h01);
        chk("ldr.MemtoRegE", 8'(MemtoRegE1), 8'h01);
        runCycle(I_NOP, 4'h0, 1'b1, 1'b1, 1'b0);
        chk("stallflush.MemtoRegE", 8'(MemtoRegE1), 8'h00);
        chk("stallflush.RegWriteM", 8'(RegWriteM1), 8'h00);

        for (int i = 0; i < 400; i++) begin
            logic [19:0] v;
            v = 20'($urandom);
            if ($urandom_range(0, 1) == 1) v[19:16] = 4'hE;
            runCycle(v, 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
